// File: rtl/systolic_drain.sv
// systolic_drain: walks matrix_index over the result diagonals of the systolic
// subarray, requantises each captured lane vector (rounding shift, optional
// ReLU, saturation) and writes the packed word to the output SRAM.
//
// Write handshake: sram_wen is the valid, sram_wready the ready. A write
// transfers on any cycle where both are 1. While sram_wen=1 and sram_wready=0
// the whole pipeline (issue counter, S1, S2, S3) holds, so sram_waddr and
// sram_wdata stay stable until the transfer happens.
module systolic_drain #(
    parameter int ARRAY_SIZE    = 16,
    parameter int OUTCOME_WIDTH = 29,
    parameter int OUT_WIDTH     = 8,
    parameter int ADDR_WIDTH    = 10
) (
    input  logic                                clk,
    input  logic                                srstn,
    input  logic                                start,
    input  logic [5:0]                          num_vec,
    input  logic [ADDR_WIDTH-1:0]               base_addr,
    input  logic [4:0]                          shift_amt,
    input  logic                                relu_en,
    input  logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] mul_outcome,
    output logic [5:0]                          matrix_index,
    output logic                                sram_wen,
    input  logic                                sram_wready,
    output logic [ADDR_WIDTH-1:0]               sram_waddr,
    output logic [ARRAY_SIZE*OUT_WIDTH-1:0]     sram_wdata,
    output logic                                busy,
    output logic                                done,
    output logic [1:0]                          dbg_state
);

    // Rounding arithmetic is one bit wider than a lane so x + 2^(s-1) never wraps.
    localparam int SW = OUTCOME_WIDTH + 1;
    localparam int PW = ARRAY_SIZE * OUT_WIDTH;
    localparam logic signed [SW-1:0] SAT_MAX = SW'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_FLUSH = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    // Latched drain configuration
    logic [5:0]            r_num_vec;
    logic [ADDR_WIDTH-1:0] r_base;
    logic [4:0]            r_shift;
    logic                  r_relu;

    logic [5:0]            r_idx;

    // Pipeline stages
    logic                                r_s1_v;
    logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] r_s1_data;
    logic [ADDR_WIDTH-1:0]               r_s1_addr;
    logic                                r_s2_v;
    logic signed [SW-1:0]                r_s2_y [ARRAY_SIZE];
    logic [ADDR_WIDTH-1:0]               r_s2_addr;
    logic                                r_s3_v;
    logic [ADDR_WIDTH-1:0]               r_s3_addr;
    logic [PW-1:0]                       r_s3_data;

    logic                  w_stall;
    logic                  w_adv;
    logic                  w_issue;
    logic                  w_last_issue;
    logic                  w_drained;
    logic                  w_busy;
    logic                  w_done;
    logic signed [SW-1:0]  w_half;
    logic signed [SW-1:0]  w_x [ARRAY_SIZE];
    logic signed [SW-1:0]  w_y [ARRAY_SIZE];
    logic [OUT_WIDTH-1:0]  w_sat [ARRAY_SIZE];
    logic [PW-1:0]         w_pack;

    assign w_stall      = r_s3_v & ~sram_wready;
    assign w_adv        = ~w_stall;
    assign w_issue      = (r_state == S_ISSUE) & w_adv;
    assign w_last_issue = w_issue & (r_idx == (r_num_vec - 6'd1));
    // Nothing left in S1/S2 and the S3 word (if any) is transferring now.
    assign w_drained    = ~r_s1_v & ~r_s2_v & (~r_s3_v | sram_wready);

    // FSM state register
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // FSM next state and status outputs
    always_comb begin
        w_next = r_state;
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_next = (num_vec == 6'd0) ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                w_busy = 1'b1;
                if (w_last_issue) w_next = S_FLUSH;
            end
            S_FLUSH: begin
                w_busy = 1'b1;
                if (w_drained) w_next = S_DONE;
            end
            S_DONE: begin
                w_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Configuration is captured only when a drain is accepted from IDLE
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_num_vec <= '0;
            r_base    <= '0;
            r_shift   <= '0;
            r_relu    <= 1'b0;
        end else if ((r_state == S_IDLE) && start) begin
            r_num_vec <= num_vec;
            r_base    <= base_addr;
            r_shift   <= shift_amt;
            r_relu    <= relu_en;
        end
    end

    // Issue counter; returns to 0 on the last issue so matrix_index idles at 0
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_idx <= '0;
        end else if (w_issue) begin
            r_idx <= w_last_issue ? 6'd0 : r_idx + 6'd1;
        end
    end

    // Per-lane rounding shift of the S1 vector (feeds S2)
    always_comb begin
        w_half = (r_shift == 5'd0) ? '0 : (SW'(1) << (r_shift - 5'd1));
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            w_x[i] = {r_s1_data[i*OUTCOME_WIDTH + OUTCOME_WIDTH - 1],
                      r_s1_data[i*OUTCOME_WIDTH +: OUTCOME_WIDTH]};
            if (r_shift == 5'd0) begin
                w_y[i] = w_x[i];
            end else if (int'(r_shift) >= OUTCOME_WIDTH) begin
                // Any lane value plus half the step lies in [0, 2^shift): rounds to 0.
                w_y[i] = '0;
            end else begin
                w_y[i] = (w_x[i] + w_half) >>> r_shift;
            end
        end
    end

    // Per-lane ReLU and saturation of the S2 vector, packed lane 0 at the MSB
    always_comb begin
        w_pack = '0;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            if (r_relu && r_s2_y[i][SW-1])  w_sat[i] = '0;
            else if (r_s2_y[i] > SAT_MAX)   w_sat[i] = SAT_MAX[OUT_WIDTH-1:0];
            else if (r_s2_y[i] < SAT_MIN)   w_sat[i] = SAT_MIN[OUT_WIDTH-1:0];
            else                            w_sat[i] = r_s2_y[i][OUT_WIDTH-1:0];
            w_pack[PW-1-i*OUT_WIDTH -: OUT_WIDTH] = w_sat[i];
        end
    end

    // Three-stage pipeline, all stages frozen together during a write stall
    always_ff @(posedge clk or negedge srstn) begin
        if (!srstn) begin
            r_s1_v    <= 1'b0;
            r_s1_data <= '0;
            r_s1_addr <= '0;
            r_s2_v    <= 1'b0;
            for (int i = 0; i < ARRAY_SIZE; i++) r_s2_y[i] <= '0;
            r_s2_addr <= '0;
            r_s3_v    <= 1'b0;
            r_s3_addr <= '0;
            r_s3_data <= '0;
        end else if (w_adv) begin
            r_s1_v <= w_issue;
            if (w_issue) begin
                r_s1_data <= mul_outcome;
                r_s1_addr <= r_base + ADDR_WIDTH'(r_idx);
            end
            r_s2_v <= r_s1_v;
            if (r_s1_v) begin
                r_s2_y    <= w_y;
                r_s2_addr <= r_s1_addr;
            end
            r_s3_v <= r_s2_v;
            if (r_s2_v) begin
                r_s3_addr <= r_s2_addr;
                r_s3_data <= w_pack;
            end
        end
    end

    assign matrix_index = r_idx;
    assign sram_wen     = r_s3_v;
    assign sram_waddr   = r_s3_addr;
    assign sram_wdata   = r_s3_data;
    assign busy         = w_busy;
    assign done         = w_done;
    assign dbg_state    = r_state;

endmodule
